// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multicycle ALU and the ALU decoder:
//   - 3-bit ALUControl op codes
//   - FSM state encoding of alu_mc
//   - helper classifying an op code as single-cycle or multicycle
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Every code other than MUL (including the undefined 111) completes in one cycle.
  function automatic logic is_multicycle(input logic [2:0] op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
// Request/response bundle between the multicycle controller and alu_mc.
//   master (controller): drives start, ALUControl, SrcA, SrcB;
//                        observes ready, done, ALUResult, Zero
//   slave  (alu_mc)    : the mirror image
// -----------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;

  modport master (
    output start, ALUControl, SrcA, SrcB,
    input  ready, done, ALUResult, Zero
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB,
    output ready, done, ALUResult, Zero
  );

endinterface

// File: rtl/alu_mc_mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter
// Iterative shift-add multiplier datapath (one partial product per step).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   load_i       : capture a_i/b_i, clear accumulator and step counter
//   step_i       : perform one shift-add iteration
//   a_i, b_i     : operands (sampled on load_i)
//   last_o       : the current step is the final (WIDTH-th) one
//   product_o    : accumulator including the current step's partial product;
//                  equals the low WIDTH bits of a*b when last_o is high
// -----------------------------------------------------------------------------
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;

  // Lookahead sum lets the controller capture the final product on the last
  // step instead of waiting an extra cycle for acc_q to settle.
  assign product_o = acc_q + (b_sh_q[0] ? a_sh_q : '0);
  assign last_o    = (cnt_q == CW'(WIDTH - 1));

  // NOTE: non-blocking (<=) in clocked blocks so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      a_sh_q <= a_i;
      b_sh_q <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q  <= product_o;
      a_sh_q <= a_sh_q << 1;
      b_sh_q <= b_sh_q >> 1;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multicycle integer ALU. add/sub/and/or/slt/sll (and the undefined code)
// produce a registered result one cycle after acceptance; mul iterates for
// WIDTH cycles in mul_iter and reports WIDTH+1 cycles after acceptance.
// Ports:
//   clk      : clock
//   reset_n  : synchronous active-low reset (aborts an in-flight multiply)
//   bus      : alu_mc_if.slave -- start/ALUControl/SrcA/SrcB in,
//              ready/done/ALUResult/Zero out
// -----------------------------------------------------------------------------
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_mc_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             mul_load;
  logic             mul_step;
  logic             mul_last;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] sc_result;

  mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (bus.SrcA),
    .b_i       (bus.SrcB),
    .last_o    (mul_last),
    .product_o (mul_product)
  );

  // Single-cycle result, taken straight from the operands presented on accept.
  always_comb begin
    sc_result = '0;
    unique case (bus.ALUControl)
      ALU_ADD: sc_result = bus.SrcA + bus.SrcB;
      ALU_SUB: sc_result = bus.SrcA - bus.SrcB;
      ALU_AND: sc_result = bus.SrcA & bus.SrcB;
      ALU_OR:  sc_result = bus.SrcA | bus.SrcB;
      ALU_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      ALU_SLL: sc_result = bus.SrcA << bus.SrcB[SHW-1:0];
      default: sc_result = '0;  // MUL is handled by mul_iter; 111 yields 0
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_multicycle(bus.ALUControl)) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            result_d = sc_result;
            zero_d   = (sc_result == '0);
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        // start is deliberately not looked at here: requests while busy are dropped.
        mul_step = 1'b1;
        if (mul_last) begin
          result_d = mul_product;
          zero_d   = (mul_product == '0);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: result/Zero are reset too, because their reset values (0 / 1) are
  // visible to the controller, unlike a pure scratch register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
// Self-checking bench for alu_mc: a table of directed vectors, hand-written
// sequences for back-to-back, busy-ignore and mid-multiply reset, and a
// randomized run checked against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_mc;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(WIDTH)) bus ();

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the op codes' arithmetic meaning, nothing more.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int signed sa, sb;
    sa = a;
    sb = b;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return prod[31:0];
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start      = s;
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from idle, wait (bounded) for done, then check latency,
  // result, Zero, busy-ready and the one-cycle done pulse with held result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                        input int exp_lat, input bit noise);
    int lat;
    bit busy_ok;
    @(negedge clk);
    check({name, " ready@issue"}, bus.ready, 1);
    drive(1'b1, op, a, b);
    tick();
    // Operands only matter on accept: scramble them afterwards.
    drive(1'b0, 3'($urandom), $urandom, $urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      if (noise) drive(1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom);
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, bus.ALUResult, exp_res);
    check({name, " zero"}, bus.Zero, exp_zero);
    if (exp_lat > 1) check({name, " ready low while busy"}, busy_ok, 1);
    tick();
    check({name, " done pulse ends"}, bus.done, 0);
    check({name, " result held"}, bus.ALUResult, exp_res);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check({name, " done timeout"}, 0, 1);
  endtask

  initial begin
    int dones;
    drive(1'b0, 3'd0, 32'd0, 32'd0);

    // ---------------- reset ----------------
    reset_n = 1'b0;
    repeat (2) tick();
    check("reset ready", bus.ready, 1);
    check("reset done", bus.done, 0);
    check("reset result", bus.ALUResult, 0);
    check("reset zero", bus.Zero, 1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("idle no done", bus.done, 0);

    // ---------------- directed table ----------------
    vecs.push_back('{"add 5+7",      ALU_ADD, 32'd5,        32'd7,        32'd12,         1'b0, 1});
    vecs.push_back('{"sub 7-7",      ALU_SUB, 32'd7,        32'd7,        32'd0,          1'b1, 1});
    vecs.push_back('{"sub 0-1",      ALU_SUB, 32'd0,        32'd1,        32'hFFFF_FFFF,  1'b0, 1});
    vecs.push_back('{"and",          ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1});
    vecs.push_back('{"or",           ALU_OR,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1});
    vecs.push_back('{"slt -1,1",     ALU_SLT, 32'hFFFF_FFFF, 32'd1,        32'd1,          1'b0, 1});
    vecs.push_back('{"slt 1,-1",     ALU_SLT, 32'd1,        32'hFFFF_FFFF, 32'd0,          1'b1, 1});
    vecs.push_back('{"sll 1,35",     ALU_SLL, 32'd1,        32'd35,       32'd8,          1'b0, 1});
    vecs.push_back('{"sll 3,31",     ALU_SLL, 32'd3,        32'd31,       32'h8000_0000,  1'b0, 1});
    vecs.push_back('{"undef 111",    3'b111,  32'd9,        32'd9,        32'd0,          1'b1, 1});
    vecs.push_back('{"mul -1*3",     ALU_MUL, 32'hFFFF_FFFF, 32'd3,        32'hFFFF_FFFD,  1'b0, 33});
    vecs.push_back('{"mul 0x10000^2", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,        1'b1, 33});
    vecs.push_back('{"mul 6*7",      ALU_MUL, 32'd6,        32'd7,        32'd42,         1'b0, 33});
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_lat, 1'b0);

    // ---------------- back-to-back: mul then add in the done cycle ----------------
    @(negedge clk);
    drive(1'b1, ALU_MUL, 32'd6, 32'd7);
    tick();
    bus.start = 1'b0;
    wait_done("b2b mul", 60);
    check("b2b mul result", bus.ALUResult, 42);
    check("b2b ready in done cycle", bus.ready, 1);
    drive(1'b1, ALU_ADD, 32'd1, 32'd1);
    tick();
    bus.start = 1'b0;
    check("b2b add done", bus.done, 1);
    check("b2b add result", bus.ALUResult, 2);
    // Single-cycle ops back to back: one result per cycle.
    @(negedge clk);
    drive(1'b1, ALU_ADD, 32'd10, 32'd20);
    tick();
    drive(1'b1, ALU_SUB, 32'd10, 32'd20);
    check("stream add result", bus.ALUResult, 30);
    tick();
    bus.start = 1'b0;
    check("stream sub done", bus.done, 1);
    check("stream sub result", bus.ALUResult, 32'hFFFF_FFF6);
    tick();

    // ---------------- start while busy is ignored ----------------
    @(negedge clk);
    drive(1'b1, ALU_MUL, 32'd9, 32'd9);
    tick();
    drive(1'b1, ALU_ADD, 32'd100, 32'd100);
    dones = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    bus.start = 1'b0;
    tick();
    check("busy add no early done", dones, 0);
    check("busy mul done", bus.done, 1);
    check("busy mul result", bus.ALUResult, 81);
    tick();
    check("busy no extra done", bus.done, 0);
    check("busy result unchanged", bus.ALUResult, 81);

    // ---------------- reset in the middle of a multiply ----------------
    @(negedge clk);
    drive(1'b1, ALU_MUL, 32'h1234, 32'h55);
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    check("abort ready", bus.ready, 1);
    check("abort result", bus.ALUResult, 0);
    check("abort zero", bus.Zero, 1);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("abort no done", dones, 0);
    run_op("post-abort add 2+2", ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1, 1'b0);

    // ---------------- randomized vs. reference model ----------------
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [31:0] a, b, r;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      r  = ref_alu(op, a, b);
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b, r, (r == 32'd0),
             (op == 3'd4) ? WIDTH + 1 : 1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
